pipelined_subtractor: RTL and testbench

//  Pipelined WIDTH-bit subtractor: diff = a - b - bin, with borrow-out and signed overflow flags.

---
 rtl/pipelined_arith_pkg.sv | 20 ++
 rtl/sub_chunk_stage.sv | 53 +++++
 rtl/pipelined_subtractor.sv | 77 +++++++
 tb/tb_pipelined_subtractor.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_arith_pkg.sv
// Shared types and defaults for the pipelined adder/subtractor pair.
// Operand bundles and result bundles used across the arithmetic pipeline.
package pipelined_arith_pkg;

    localparam int ARITH_WIDTH  = 32;
    localparam int ARITH_STAGES = 4;

    typedef struct packed {
        logic [ARITH_WIDTH-1:0] a;
        logic [ARITH_WIDTH-1:0] b;
        logic                   bin;
    } arith_op_t;

    typedef struct packed {
        logic [ARITH_WIDTH-1:0] diff;
        logic                   bout;
        logic                   ovf;
    } sub_res_t;

endpackage

// File: rtl/sub_chunk_stage.sv
// One registered borrow slice: resolves diff chunk K from the skewed operands.
// Operands and resolved diff chunks ride along so later slices see them.
module sub_chunk_stage #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_prev,
    input  logic [WIDTH-1:0] a_prev,
    input  logic [WIDTH-1:0] b_prev,
    input  logic [WIDTH-1:0] diff_prev,
    input  logic             brw_prev,
    output logic             valid,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             brw
);

    localparam int LO = K * CHUNK;

    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] diff_nxt;

    // a - b - borrow == a + ~b + !borrow; carry-out set means no borrow
    always_comb begin
        sum = {1'b0, a_prev[LO +: CHUNK]}
            + {1'b0, ~b_prev[LO +: CHUNK]}
            + {{CHUNK{1'b0}}, !brw_prev};
        diff_nxt = diff_prev;
        diff_nxt[LO +: CHUNK] = sum[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            a     <= '0;
            b     <= '0;
            diff  <= '0;
            brw   <= 1'b0;
        end else if (en) begin
            valid <= valid_prev;
            a     <= a_prev;
            b     <= b_prev;
            diff  <= diff_nxt;
            brw   <= !sum[CHUNK];
        end
    end

endmodule

// File: rtl/pipelined_subtractor.sv
// Pipelined a - b - bin with borrow-out and signed overflow.
// The last slice doubles as the output register; one global enable stalls all.
module pipelined_subtractor
    import pipelined_arith_pkg::*;
#(
    parameter int WIDTH  = ARITH_WIDTH,
    parameter int STAGES = ARITH_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("WIDTH must be a multiple of STAGES");
    end

    logic                         en;
    logic [STAGES:0]              v;
    logic [STAGES:0]              br;
    logic [STAGES:0][WIDTH-1:0]   sa;
    logic [STAGES:0][WIDTH-1:0]   sb;
    logic [STAGES:0][WIDTH-1:0]   sd;
    logic                         unused_bits;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign v[0]  = in_valid;
    assign sa[0] = a;
    assign sb[0] = b;
    assign sd[0] = '0;
    assign br[0] = bin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        sub_chunk_stage #(
            .WIDTH(WIDTH),
            .CHUNK(CHUNK),
            .K    (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .valid_prev(v[k]),
            .a_prev    (sa[k]),
            .b_prev    (sb[k]),
            .diff_prev (sd[k]),
            .brw_prev  (br[k]),
            .valid     (v[k+1]),
            .a         (sa[k+1]),
            .b         (sb[k+1]),
            .diff      (sd[k+1]),
            .brw       (br[k+1])
        );
    end

    assign out_valid = v[STAGES];
    assign diff      = sd[STAGES];
    assign bout      = br[STAGES];
    assign ovf       = (sa[STAGES][WIDTH-1] != sb[STAGES][WIDTH-1])
                    && (sd[STAGES][WIDTH-1] != sa[STAGES][WIDTH-1]);

    // Only the operand sign bits are needed past the last slice
    assign unused_bits = ^{sa[STAGES][WIDTH-2:0], sb[STAGES][WIDTH-2:0]};

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Directed bench for pipelined_subtractor: latency, wrap, ripple,
// throughput, backpressure and mid-flight reset.
module tb_pipelined_subtractor;
    import pipelined_arith_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    pipelined_subtractor #(.WIDTH(32), .STAGES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic sub_res_t model(input logic [31:0] x, input logic [31:0] y,
                                       input logic c);
        logic [32:0] t;
        sub_res_t    r;
        t      = {1'b0, x} - {1'b0, y} - {32'b0, c};
        r.diff = t[31:0];
        r.bout = t[32];
        r.ovf  = (x[31] != y[31]) && (t[31] != x[31]);
        return r;
    endfunction

    // Drives one op with out_ready=1 and captures the result; no checking here
    task automatic issue(input logic [31:0] a_v, input logic [31:0] b_v,
                         input logic bin_v, output int lat,
                         output sub_res_t r, output logic v_after);
        @(negedge clk);
        a = a_v;
        b = b_v;
        bin = bin_v;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r.diff = diff;
        r.bout = bout;
        r.ovf = ovf;
        @(negedge clk);
        v_after = out_valid;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (diff !== 32'h0) begin
            errors++;
            $display("FAIL reset diff: got %h want 00000000", diff);
        end
        checks++;
        if ({bout, ovf} !== 2'b00) begin
            errors++;
            $display("FAIL reset bout/ovf: got %b%b want 00", bout, ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        int       lat;
        sub_res_t r;
        logic     va;
        issue(32'd5, 32'd2, 1'b0, lat, r, va);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL basic latency: got %0d want 4", lat);
        end
        checks++;
        if (r !== {32'h00000003, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic 5-2: got %h/%b/%b want 00000003/0/0",
                     r.diff, r.bout, r.ovf);
        end
        checks++;
        if (va !== 1'b0) begin
            errors++;
            $display("FAIL basic one-cycle valid: got %b want 0", va);
        end
    endtask

    task automatic test_wrap;
        int       lat;
        sub_res_t r;
        logic     va;
        issue(32'h00000000, 32'h00000001, 1'b0, lat, r, va);
        checks++;
        if (r !== {32'hFFFFFFFF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap 0-1: got %h/%b/%b want ffffffff/1/0",
                     r.diff, r.bout, r.ovf);
        end
        issue(32'h80000000, 32'h00000001, 1'b0, lat, r, va);
        checks++;
        if (r !== {32'h7FFFFFFF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wrap min-1: got %h/%b/%b want 7fffffff/0/1",
                     r.diff, r.bout, r.ovf);
        end
    endtask

    task automatic test_ripple;
        int       lat;
        sub_res_t r;
        logic     va;
        issue(32'h01000000, 32'h00000001, 1'b0, lat, r, va);
        checks++;
        if (r !== {32'h00FFFFFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ripple 01000000-1: got %h/%b/%b want 00ffffff/0/0",
                     r.diff, r.bout, r.ovf);
        end
        issue(32'h000000AB, 32'h000000CD, 1'b1, lat, r, va);
        checks++;
        if (r !== {32'hFFFFFFDD, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ripple ab-cd-1: got %h/%b/%b want ffffffdd/1/0",
                     r.diff, r.bout, r.ovf);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] va[10];
        logic [31:0] vb[10];
        logic        vc[10];
        sub_res_t    e;
        for (int j = 0; j < 10; j++) begin
            va[j] = 32'h11111111 * j + 32'h00F0_0000;
            vb[j] = 32'h22220003 * j;
            vc[j] = j[0];
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (i >= 4 && i < 14)) begin
                errors++;
                $display("FAIL b2b valid cycle %0d: got %b want %b",
                         i, out_valid, (i >= 4 && i < 14));
            end
            if (i >= 4 && i < 14) begin
                e = model(va[i-4], vb[i-4], vc[i-4]);
                checks++;
                if ({diff, bout, ovf} !== e) begin
                    errors++;
                    $display("FAIL b2b result %0d: got %h/%b/%b want %h/%b/%b",
                             i - 4, diff, bout, ovf, e.diff, e.bout, e.ovf);
                end
            end
            if (i < 10) begin
                a = va[i];
                b = vb[i];
                bin = vc[i];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] pa[5] = '{32'h00000010, 32'h7FFFFFFF, 32'h00000000,
                               32'hDEADBEEF, 32'h12345678};
        logic [31:0] pb[5] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000,
                               32'h0000BEEF, 32'h12345679};
        logic        pc[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        sub_res_t    q[$];
        sub_res_t    e;
        int          sent = 0;
        int          got = 0;
        int          stall_left = 0;
        bit          stalled = 0;
        logic [31:0] held = '0;
        for (int i = 0; i < 60 && got < 5; i++) begin
            @(negedge clk);
            if (!stalled && out_valid) begin
                stalled = 1;
                stall_left = 3;
                held = diff;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                checks++;
                if (diff !== held || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall hold: got %h/%b want %h/1",
                             diff, out_valid, held);
                end
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp unexpected result: got %h want none", diff);
                end else begin
                    e = q.pop_front();
                    if ({diff, bout, ovf} !== e) begin
                        errors++;
                        $display("FAIL bp result %0d: got %h/%b/%b want %h/%b/%b",
                                 got, diff, bout, ovf, e.diff, e.bout, e.ovf);
                    end
                end
                got++;
            end
            if (sent < 5) begin
                a = pa[sent];
                b = pb[sent];
                bin = pc[sent];
                in_valid = 1'b1;
            end else begin
                a = 32'hFFFFFFFF;
                b = 32'h0;
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall in_ready: got %b want 0", in_ready);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(pa[sent], pb[sent], pc[sent]));
                sent++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 5 || stalled !== 1'b1) begin
            errors++;
            $display("FAIL bp count: got %0d results stalled=%b want 5 and 1",
                     got, stalled);
        end
    endtask

    task automatic test_midflight_reset;
        int       lat;
        sub_res_t r;
        logic     va;
        out_ready = 1'b1;
        @(negedge clk);
        a = 32'h00000100;
        b = 32'h00000001;
        bin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        a = 32'h00000200;
        @(negedge clk);
        a = 32'h00000300;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (diff !== 32'h0) begin
            errors++;
            $display("FAIL midrst diff cleared: got %h want 00000000", diff);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst out_valid cycle %0d: got %b want 0",
                         i, out_valid);
            end
            @(negedge clk);
        end
        issue(32'h00000010, 32'h00000003, 1'b0, lat, r, va);
        checks++;
        if (lat !== 4 || r !== {32'h0000000D, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst new op: got lat %0d %h/%b/%b want 4 0000000d/0/0",
                     lat, r.diff, r.bout, r.ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ripple();
        test_back_to_back();
        test_backpressure();
        test_midflight_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
